// File: rtl/prefix_pkg.sv
// Shared types and constants for the parallel-prefix subtractor pipeline.
// gp_t carries a (generate, propagate) pair through the carry tree.
package prefix_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int LEVELS        = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/gp_combine_cell.sv
// One Kogge-Stone tree node: (G,P)o(G',P') = (G | P&G', P&P').
// i_hi is the more significant span, i_lo the adjacent less significant one.
module gp_combine_cell
    import prefix_pkg::*;
(
    input  gp_t i_hi,
    input  gp_t i_lo,
    output gp_t o_gp
);

    assign o_gp.g = i_hi.g | (i_hi.p & i_lo.g);
    assign o_gp.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/prefix16_sub_pipe.sv
// Three-stage pipelined a - b using a Kogge-Stone carry tree (levels 1-2
// between S1 and S2, levels 3-4 between S2 and S3) with valid/ready flow control.
module prefix16_sub_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both 1. Each stage advances when empty or when its successor
    // advances, so in_ready depends only on valid bits and out_ready.
    logic w_adv1, w_adv2, w_adv3;
    logic r_v1, r_v2, r_v3;

    assign w_adv3    = !r_v3 || out_ready;
    assign w_adv2    = !r_v2 || w_adv3;
    assign w_adv1    = !r_v1 || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v3;

    // Preprocessing for a + ~b + 1: the carry-in is folded into bit 0.
    gp_t [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_hp;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_pre[i].g = a[i] & ~b[i];
            w_pre[i].p = a[i] ^ ~b[i];
        end
        w_pre[0].g = a[0] | ~b[0];
        w_pre[0].p = 1'b0;
    end

    assign w_hp = a ^ ~b;

    gp_t [WIDTH-1:0]  r1_gp;
    logic [WIDTH-1:0] r1_hp;
    gp_t [WIDTH-1:0]  r2_gp;
    logic [WIDTH-1:0] r2_hp;
    gp_t [WIDTH-1:0]  w_l1, w_l2, w_l3, w_l4;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tree
        if (i >= 1) begin : g_l1
            gp_combine_cell u_cell (.i_hi(r1_gp[i]), .i_lo(r1_gp[i-1]), .o_gp(w_l1[i]));
        end else begin : g_l1_pass
            assign w_l1[i] = r1_gp[i];
        end

        if (i >= 2) begin : g_l2
            gp_combine_cell u_cell (.i_hi(w_l1[i]), .i_lo(w_l1[i-2]), .o_gp(w_l2[i]));
        end else begin : g_l2_pass
            assign w_l2[i] = w_l1[i];
        end

        if (i >= 4) begin : g_l3
            gp_combine_cell u_cell (.i_hi(r2_gp[i]), .i_lo(r2_gp[i-4]), .o_gp(w_l3[i]));
        end else begin : g_l3_pass
            assign w_l3[i] = r2_gp[i];
        end

        if (i >= 8) begin : g_l4
            gp_combine_cell u_cell (.i_hi(w_l3[i]), .i_lo(w_l3[i-8]), .o_gp(w_l4[i]));
        end else begin : g_l4_pass
            assign w_l4[i] = w_l3[i];
        end
    end

    // After the last level every g is the carry out of bit i; the group P of a
    // full prefix is always 0 because bit 0 has P=0, so it is not needed.
    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;
    logic [WIDTH-1:0] w_cin;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = w_l4[i].g;
            w_unused_p = w_unused_p | w_l4[i].p;
        end
    end

    assign w_cin  = {w_carry[WIDTH-2:0], 1'b1};
    assign w_diff = r2_hp ^ w_cin;

    logic [WIDTH-1:0] r_diff;
    logic             r_borrow, r_ovf, r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r1_gp    <= '0;
            r1_hp    <= '0;
            r2_gp    <= '0;
            r2_hp    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;

            if (w_adv1 && in_valid) begin
                r1_gp <= w_pre;
                r1_hp <= w_hp;
            end
            if (w_adv2 && r_v1) begin
                r2_gp <= w_l2;
                r2_hp <= r1_hp;
            end
            if (w_adv3 && r_v2) begin
                r_diff   <= w_diff;
                r_borrow <= ~w_carry[WIDTH-1];
                r_ovf    <= w_carry[WIDTH-2] ^ w_carry[WIDTH-1];
                r_zero   <= (w_diff == '0);
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule
